fir_mac_scheduler: RTL and testbench

Time-multiplexed FIR controller that shares one multiplier/accumulator across all taps.
- Accepts one input sample per valid/ready handshake and writes it into a circular delay line.
- Sequences TAPS multiply-accumulate cycles against a run-time-loadable coefficient bank.
- Presents the rounded, saturated result on a valid/ready output.
- Sits between the sample source and the downstream decimator/sink; it is the area-optimised alternative to the fully parallel fir_filter.

---
 rtl/fir_sched_pkg.sv | 31 +++
 rtl/fir_delay_line.sv | 44 ++++
 rtl/fir_mac_scheduler.sv | 114 +++++++++++
 tb/tb_fir_mac_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the time-multiplexed FIR family.
// round_sat works on a 64-bit container so any accumulator up to 63 bits can reuse it.
package fir_sched_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    function automatic int prod_width(input int data_width, input int coef_width);
        return data_width + coef_width;
    endfunction

    function automatic int idx_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Round half up, arithmetic shift, then clamp to a signed data_width range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int shift,
                                                     input int data_width);
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        // NOTE: blocking assignments are right here; these are function locals, not state.
        y  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_width - 1));
        if (y > hi) return hi;
        if (y < lo) return lo;
        return y;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write port advancing wr_ptr, one read port at (base - offset) mod TAPS.
module fir_delay_line
    import fir_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 32,
    parameter int IDX_WIDTH  = idx_width(TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic        [IDX_WIDTH-1:0]  base,
    input  logic        [IDX_WIDTH-1:0]  offset,
    output logic        [IDX_WIDTH-1:0]  wr_ptr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    localparam logic [IDX_WIDTH-1:0] LAST   = IDX_WIDTH'(TAPS - 1);
    localparam logic [IDX_WIDTH-1:0] TAPS_M = IDX_WIDTH'(TAPS);

    logic signed [DATA_WIDTH-1:0] line [TAPS];
    logic        [IDX_WIDTH-1:0]  rd_idx;

    // Explicit compare keeps the wrap correct for non-power-of-2 depths.
    always_comb begin
        if (offset > base) rd_idx = base + TAPS_M - offset;
        else               rd_idx = base - offset;
    end

    assign rd_data = line[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            // NOTE: the line is reset on purpose so an aborted or fresh filter starts from silence.
            for (int i = 0; i < TAPS; i++) line[i] <= '0;
        end else if (wr_en) begin
            line[wr_ptr] <= wr_data;
            wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Single-MAC FIR: accepts a sample, runs TAPS multiply-accumulate cycles, then
// presents a rounded and saturated result on a valid/ready output.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int TAPS       = 32,
    parameter int OUT_SHIFT  = 15,
    localparam int IDX_WIDTH  = idx_width(TAPS),
    localparam int PROD_WIDTH = prod_width(DATA_WIDTH, COEF_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         coef_we,
    input  logic        [IDX_WIDTH-1:0]  coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wdata,
    output logic                         coef_err,
    output logic                         busy
);

    localparam logic [IDX_WIDTH-1:0] LAST   = IDX_WIDTH'(TAPS - 1);
    localparam logic [IDX_WIDTH:0]   TAPS_W = (IDX_WIDTH + 1)'(TAPS);

    state_t                       state;
    logic        [IDX_WIDTH-1:0]  k;
    logic        [IDX_WIDTH-1:0]  base;
    logic        [IDX_WIDTH-1:0]  wr_ptr;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic signed [COEF_WIDTH-1:0] coef [TAPS];
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic                         accept;
    logic                         coef_ok;

    // A coefficient write in IDLE wins over a pending sample so the sample never sees a half-updated bank.
    assign in_ready = (state == IDLE) && !coef_we && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign coef_ok  = (state == IDLE) && ({1'b0, coef_addr} < TAPS_W);
    assign acc_sum  = acc + {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    fir_delay_line #(
        .DATA_WIDTH(DATA_WIDTH),
        .TAPS      (TAPS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_line (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .wr_data(in_data),
        .base   (base),
        .offset (k),
        .wr_ptr (wr_ptr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            base      <= '0;
            prod      <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else begin
            coef_err <= coef_we && !coef_ok;
            if (coef_we && coef_ok) coef[coef_addr] <= coef_wdata;

            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        k     <= '0;
                        base  <= wr_ptr;
                        state <= MAC;
                    end
                end
                MAC: begin
                    // The product lags the read by one cycle, so the first MAC cycle has nothing to add.
                    prod <= PROD_WIDTH'(coef[k]) * PROD_WIDTH'(rd_data);
                    if (k != '0) acc <= acc_sum;
                    if (k == LAST) state <= DRAIN;
                    else           k     <= k + 1'b1;
                end
                DRAIN: begin
                    acc       <= acc_sum;
                    out_data  <= DATA_WIDTH'(round_sat(64'(acc_sum), OUT_SHIFT, DATA_WIDTH));
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: a 32-tap instance for the main checks and a
// 5-tap instance for out-of-range coefficient addresses and non-power-of-2 wrap.
module tb_fir_mac_scheduler;

    localparam int TAPS  = 32;
    localparam int TAPS5 = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic signed [15:0] in_data, out_data, coef_wdata;
    logic               coef_we, coef_err, busy;
    logic        [4:0]  coef_addr;

    logic               in_valid_5, in_ready_5, out_valid_5, out_ready_5;
    logic signed [15:0] in_data_5, out_data_5, coef_wdata_5;
    logic               coef_we_5, coef_err_5, busy_5;
    logic        [2:0]  coef_addr_5;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fir_mac_scheduler #(.TAPS(TAPS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_err(coef_err), .busy(busy)
    );

    fir_mac_scheduler #(.TAPS(TAPS5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_5), .in_ready(in_ready_5), .in_data(in_data_5),
        .out_valid(out_valid_5), .out_ready(out_ready_5), .out_data(out_data_5),
        .coef_we(coef_we_5), .coef_addr(coef_addr_5), .coef_wdata(coef_wdata_5),
        .coef_err(coef_err_5), .busy(busy_5)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coef_write(input int addr, input int data);
        coef_we    = 1'b1;
        coef_addr  = 5'(addr);
        coef_wdata = 16'(data);
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic coef_write5(input int addr, input int data);
        coef_we_5    = 1'b1;
        coef_addr_5  = 3'(addr);
        coef_wdata_5 = 16'(data);
        tick();
        coef_we_5    = 1'b0;
    endtask

    // Sends one sample, waits for the result, completes the handshake (out_ready high).
    // lat counts cycles from the accepting cycle to the first cycle with out_valid high.
    task automatic send(input int x, output int y, output int lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        in_valid = 1'b1;
        in_data  = 16'(x);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        if (lat >= 100) check("out_valid_timeout", 32'(out_valid), 1);
        y = int'(out_data);
        tick();
    endtask

    task automatic send5(input int x, output int y, output int lat);
        int n;
        n = 0;
        while (in_ready_5 !== 1'b1 && n < 50) begin tick(); n++; end
        in_valid_5 = 1'b1;
        in_data_5  = 16'(x);
        tick();
        in_valid_5 = 1'b0;
        lat = 1;
        while (out_valid_5 !== 1'b1 && lat < 100) begin tick(); lat++; end
        if (lat >= 100) check("out_valid5_timeout", 32'(out_valid_5), 1);
        y = int'(out_data_5);
        tick();
    endtask

    initial begin
        int y, lat, seen;
        int exp5 [7];

        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        out_ready_5 = 1'b1; in_valid_5 = 1'b0; in_data_5 = '0;
        coef_we_5 = 1'b0; coef_addr_5 = '0; coef_wdata_5 = '0;

        // Reset state
        tick(); tick();
        check("rst_in_ready",  32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data), 0);
        check("rst_coef_err",  32'(coef_err), 0);
        check("rst_busy",      32'(busy), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 1);

        // Single tap 0.5, latency
        coef_write(0, 16384);
        send(1000, y, lat);
        check("basic_out",          y, 500);
        check("basic_latency",      lat, TAPS + 2);
        check("out_valid_after_hs", 32'(out_valid), 0);
        check("busy_after_hs",      32'(busy), 0);

        // Impulse response: (1000+n)/2 rounded half up
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < TAPS; i++) coef_write(i, 1000 + i);
        for (int n = 0; n < TAPS; n++) begin
            send((n == 0) ? 16384 : 0, y, lat);
            check($sformatf("impulse_%0d", n), y, (1001 + n) / 2);
        end

        // Saturation at both rails
        for (int i = 0; i < TAPS; i++) coef_write(i, 32767);
        for (int n = 0; n < TAPS; n++) send(32767, y, lat);
        check("sat_pos", y, 32767);
        for (int n = 0; n < TAPS; n++) send(-32768, y, lat);
        check("sat_neg", y, -32768);

        // Backpressure: result held for 10 cycles with out_ready low
        rst = 1'b1; tick(); rst = 1'b0;
        coef_write(0, 16384);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'sd1234;
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (out_valid !== 1'b1 && seen < 100) begin tick(); seen++; end
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_valid_%0d", c), 32'(out_valid), 1);
            check($sformatf("bp_data_%0d", c),  32'(out_data), 617);
            check($sformatf("bp_ready_%0d", c), 32'(in_ready), 0);
            check($sformatf("bp_busy_%0d", c),  32'(busy), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_valid_after", 32'(out_valid), 0);
        check("bp_busy_after",  32'(busy), 0);
        check("bp_ready_after", 32'(in_ready), 1);
        check("bp_data_kept",   32'(out_data), 617);

        // Coefficient write during MAC is dropped with a one-cycle coef_err
        in_valid = 1'b1; in_data = 16'sd2000;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        coef_we = 1'b1; coef_addr = 5'd1; coef_wdata = 16'sd16384;
        check("mac_err_before", 32'(coef_err), 0);
        tick();
        coef_we = 1'b0;
        check("mac_err_pulse", 32'(coef_err), 1);
        tick();
        check("mac_err_clear", 32'(coef_err), 0);
        seen = 0;
        while (out_valid !== 1'b1 && seen < 100) begin tick(); seen++; end
        check("mac_out_unchanged", 32'(out_data), 1000);
        tick();
        send(0, y, lat);
        check("mac_bank_unchanged", y, 0);

        // Coefficient write in IDLE defers a coincident sample
        coef_we = 1'b1; coef_addr = 5'd2; coef_wdata = 16'sd16384;
        in_valid = 1'b1; in_data = 16'sd100;
        #1;
        check("idle_we_in_ready", 32'(in_ready), 0);
        tick();
        coef_we = 1'b0; in_valid = 1'b0;
        check("idle_we_deferred", 32'(busy), 0);
        send(100, y, lat);
        check("idle_we_effect", y, 1050);

        // Reset mid-MAC at k=10
        in_valid = 1'b1; in_data = 16'sd3000;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_busy",     32'(busy), 0);
        check("abort_out_data", 32'(out_data), 0);
        seen = 0;
        for (int c = 0; c < TAPS + 4; c++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        check("abort_no_out_valid", seen, 0);
        coef_write(1, 16384);
        send(0, y, lat);
        check("abort_line_cleared", y, 0);
        send(500, y, lat);
        check("abort_coef_cleared", y, 0);

        // 5-tap instance: out-of-range address, then wrap with y = x/2 + x[-1]/4
        coef_write5(5, 1234);
        check("addr_taps_err", 32'(coef_err_5), 1);
        coef_write5(7, 1234);
        check("addr_max_err", 32'(coef_err_5), 1);
        coef_write5(0, 16384);
        check("addr_ok_no_err", 32'(coef_err_5), 0);
        coef_write5(1, 8192);
        exp5 = '{50, 125, 200, 275, 350, 425, 500};
        for (int n = 0; n < 7; n++) begin
            send5((n + 1) * 100, y, lat);
            check($sformatf("wrap5_%0d", n), y, exp5[n]);
        end
        check("wrap5_latency", lat, TAPS5 + 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
